fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the decode stage; owns the fetch PC, issues SRAM-style requests (req/addr_ok/data_ok) to the instruction bus, and tracks in-flight requests.
- Keeps a small FIFO of accepted fetch PCs, which is the head presented to decode as valid/pc/exception.
- On redirect (branch/exception/eret) it flushes the FIFO and squashes stale bus responses, so decode only ever sees inst_data_ok for live fetches.

---
 rtl/fetch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the fetch PC, issues SRAM-style
// requests, tracks in-flight fetches and squashes stale responses after redirects.
// Params: MAX_OUT (1..4) outstanding limit / FIFO depth, RESET_PC fetch PC after reset.
// Ports:
//   clk, resetn           clock, async active-low reset
//   inst_req/inst_addr    bus request (held with stable addr until inst_addr_ok)
//   inst_addr_ok          request accepted this cycle
//   inst_data_ok          in-order bus response
//   data_ok_o             response for a live fetch (stale ones filtered)
//   redirect_i/_pc_i      one-cycle restart pulse and target
//   accept_i              decode consumed head entry
//   valid_o/pc_o/exc_o    FIFO head; exccode_o = AdEL when exc_o
// Optional: define FETCH_PERFCNT_EN to add perfcnt_discard / perfcnt_stall.
module fetch_ctrl #(
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        data_ok_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        accept_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic        exc_o,
  output logic [4:0]  exccode_o
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0] perfcnt_discard,
  output logic [31:0] perfcnt_stall
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUT);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUT - 1);
  localparam logic [4:0]    ADEL  = 5'h04;

  typedef enum logic {
    FETCH,
    HALT
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     fifo_pc  [MAX_OUT];
  logic            fifo_exc [MAX_OUT];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard_cnt;
  logic            redir_pend;
  logic [31:0]     redir_pc;

  logic            acc;
  logic            dok;
  logic            redir_hold;
  logic            redir_now;
  logic            pend_done;
  logic            flush;
  logic            push;
  logic            push_exc;
  logic            pop;
  logic [CW-1:0]   inflight_n;
  logic [CW-1:0]   cnt_n;
  logic [CW-1:0]   discard_n;
  logic [31:0]     pc_n;
  state_t          state_n;
  logic            redir_pend_n;
  logic            req_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + PW'(1);
  endfunction

  assign inst_addr = pc;
  assign valid_o   = (fifo_cnt != '0);
  assign pc_o      = fifo_pc[rd_ptr];
  assign exc_o     = valid_o & fifo_exc[rd_ptr];
  assign exccode_o = exc_o ? ADEL : 5'h00;
  // A response with nothing in flight is spurious and never forwarded.
  assign data_ok_o = inst_data_ok & (inflight != '0) & (discard_cnt == '0);

  always_comb begin
    acc        = inst_req & inst_addr_ok;
    dok        = inst_data_ok & (inflight != '0);
    // A redirect cannot retract a pending request; park the target instead.
    redir_hold = redirect_i & inst_req & ~inst_addr_ok;
    redir_now  = redirect_i & ~redir_hold;
    pend_done  = redir_pend & acc & ~redirect_i;
    flush      = redirect_i | pend_done;
    push_exc   = (state == FETCH) & (pc[1:0] != 2'b00)
               & (fifo_cnt < MAXC) & ~redirect_i;
    push       = (acc & ~redir_pend & ~redirect_i) | push_exc;
    pop        = accept_i & valid_o & ~redirect_i;

    inflight_n = inflight + CW'(acc) - CW'(dok);
    cnt_n      = fifo_cnt + CW'(push) - CW'(pop);
    discard_n  = discard_cnt - CW'(dok & (discard_cnt != '0));
    if (flush) begin
      cnt_n     = '0;
      // Everything still on the bus belongs to the old stream.
      discard_n = inflight_n;
    end

    pc_n    = pc;
    state_n = state;
    if (redir_now) begin
      pc_n    = redirect_pc_i;
      state_n = FETCH;
    end else if (pend_done) begin
      pc_n    = redir_pc;
      state_n = FETCH;
    end else if (acc) begin
      pc_n    = pc + 32'd4;
    end else if (push_exc) begin
      state_n = HALT;
    end

    redir_pend_n = redir_hold | (redir_pend & ~acc);

    // Registered request: evaluated on next-cycle state so it never drops
    // before inst_addr_ok.
    req_n = (state_n == FETCH) & (pc_n[1:0] == 2'b00)
          & (cnt_n < MAXC) & (inflight_n < MAXC);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      inflight    <= '0;
      discard_cnt <= '0;
      redir_pend  <= 1'b0;
      redir_pc    <= '0;
      inst_req    <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_pc[i]  <= '0;
        fifo_exc[i] <= 1'b0;
      end
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fifo_cnt    <= cnt_n;
      inflight    <= inflight_n;
      discard_cnt <= discard_n;
      redir_pend  <= redir_pend_n;
      inst_req    <= req_n;
      if (redir_hold) begin
        redir_pc <= redirect_pc_i;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]  <= pc;
          fifo_exc[wr_ptr] <= push_exc;
          wr_ptr           <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
      end
    end
  end

`ifdef FETCH_PERFCNT_EN
  logic stall;

  assign stall = (state == FETCH) & (pc[1:0] == 2'b00) & ~redir_pend
               & ((fifo_cnt >= MAXC) | (inflight >= MAXC));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perfcnt_discard <= '0;
      perfcnt_stall   <= '0;
    end else begin
      if (dok & (discard_cnt != '0)) begin
        perfcnt_discard <= perfcnt_discard + 32'd1;
      end
      if (stall) begin
        perfcnt_stall <= perfcnt_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl.
// Bus responder answers one cycle after acceptance; decode accepts live data.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic        data_ok_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        accept_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic        exc_o;
  logic [4:0]  exccode_o;
`ifdef FETCH_PERFCNT_EN
  logic [31:0] perfcnt_discard;
  logic [31:0] perfcnt_stall;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        live;
    logic [31:0] pc;
  } sb_t;

  sb_t         sb[$];
  logic        rsp_en   = 1'b0;
  logic        auto_acc = 1'b0;
  logic        man_acc  = 1'b0;
  logic        pend_m   = 1'b0;
  logic [31:0] model_pc = RST_PC;
  logic [31:0] tgt_m    = '0;

  fetch_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_ok_o    (data_ok_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .accept_i     (accept_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .exc_o        (exc_o),
    .exccode_o    (exccode_o)
`ifdef FETCH_PERFCNT_EN
    ,
    .perfcnt_discard(perfcnt_discard),
    .perfcnt_stall  (perfcnt_stall)
`endif
  );

  always #5 clk = ~clk;

  // Bus responder and decode model.
  always @(posedge clk) begin
    #2;
    inst_data_ok = rsp_en && resetn && (sb.size() > 0);
    if (auto_acc) begin
      accept_i = 1'b0;
      if (inst_data_ok) begin
        accept_i = sb[0].live;
      end
    end else begin
      accept_i = man_acc;
    end
  end

  // Scoreboard: expected liveness/pc pushed on acceptance, popped on response.
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      pend_m   = 1'b0;
      model_pc = RST_PC;
    end else begin
      if (inst_data_ok) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL sb_empty: data_ok with nothing expected");
        end else begin
          sb_t e;
          e = sb.pop_front();
          total++;
          if (data_ok_o !== e.live)
            $display("FAIL sb_data_ok: got %b exp %b", data_ok_o, e.live);
          else passed++;
          if (e.live && auto_acc) begin
            total++;
            if (pc_o !== e.pc)
              $display("FAIL sb_pc: got %h exp %h", pc_o, e.pc);
            else passed++;
          end
        end
      end
      if (redirect_i) begin
        foreach (sb[i]) sb[i].live = 1'b0;
      end
      if (inst_req && inst_addr_ok) begin
        sb_t n;
        total++;
        if (inst_addr !== model_pc)
          $display("FAIL sb_addr: got %h exp %h", inst_addr, model_pc);
        else passed++;
        n.live = !(redirect_i || pend_m);
        n.pc   = model_pc;
        sb.push_back(n);
        if (!redirect_i && !pend_m) model_pc = model_pc + 32'd4;
        else if (!redirect_i && pend_m) begin
          model_pc = tgt_m;
          pend_m   = 1'b0;
        end
      end
      if (redirect_i) begin
        if (inst_req && !inst_addr_ok) begin
          pend_m = 1'b1;
          tgt_m  = redirect_pc_i;
        end else begin
          pend_m   = 1'b0;
          model_pc = redirect_pc_i;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    inst_addr_ok  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    man_acc       = 1'b0;
    auto_acc      = 1'b0;
    rsp_en        = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    @(negedge clk);
    total++; if (inst_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", inst_req); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %b exp 0", valid_o); else passed++;
    total++; if (exc_o !== 1'b0) $display("FAIL rst_exc: got %b exp 0", exc_o); else passed++;
    total++; if (exccode_o !== 5'h00) $display("FAIL rst_code: got %h exp 00", exccode_o); else passed++;
    total++; if (data_ok_o !== 1'b0) $display("FAIL rst_dok: got %b exp 0", data_ok_o); else passed++;
    total++; if (inst_addr !== RST_PC) $display("FAIL rst_addr: got %h exp %h", inst_addr, RST_PC); else passed++;
  endtask

  task automatic test_sequential();
    int n = 0;
    do_reset();
    rsp_en = 1'b1; auto_acc = 1'b1; inst_addr_ok = 1'b1;
    for (int c = 0; c < 12 && n < 3; c++) begin
      @(negedge clk);
      if (inst_req && inst_addr_ok) begin
        total++;
        if (inst_addr !== RST_PC + 32'(4 * n))
          $display("FAIL seq_addr%0d: got %h exp %h", n, inst_addr, RST_PC + 32'(4 * n));
        else passed++;
        n++;
      end
      tick();
    end
    total++; if (n != 3) $display("FAIL seq_count: got %0d exp 3", n); else passed++;
    repeat (3) tick();
    inst_addr_ok = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_max_out();
    int n = 0;
    do_reset();
    rsp_en = 1'b1; inst_addr_ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (inst_req && inst_addr_ok) n++;
      tick();
    end
    @(negedge clk);
    total++; if (n != 2) $display("FAIL max_count: got %0d exp 2", n); else passed++;
    total++; if (inst_req !== 1'b0) $display("FAIL max_req: got %b exp 0", inst_req); else passed++;
    total++; if (valid_o !== 1'b1) $display("FAIL max_valid: got %b exp 1", valid_o); else passed++;
    total++; if (pc_o !== RST_PC) $display("FAIL max_head: got %h exp %h", pc_o, RST_PC); else passed++;
    tick(); man_acc = 1'b1;
    tick(); man_acc = 1'b0;
    @(negedge clk);
    total++; if (inst_req !== 1'b1) $display("FAIL max_rereq: got %b exp 1", inst_req); else passed++;
    total++; if (inst_addr !== RST_PC + 32'd8) $display("FAIL max_addr: got %h exp %h", inst_addr, RST_PC + 32'd8); else passed++;
    total++; if (pc_o !== RST_PC + 32'd4) $display("FAIL max_head2: got %h exp %h", pc_o, RST_PC + 32'd4); else passed++;
    tick();
  endtask

  task automatic test_redirect_inflight();
    int k = 0;
    do_reset();
    auto_acc = 1'b1; inst_addr_ok = 1'b1;
    repeat (4) tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h80001000;
    tick();
    redirect_i = 1'b0; rsp_en = 1'b1;
    for (int c = 0; c < 12 && k < 3; c++) begin
      @(negedge clk);
      if (inst_data_ok) begin
        k++;
        if (k < 3) begin
          total++;
          if (data_ok_o !== 1'b0) $display("FAIL rdi_stale%0d: got %b exp 0", k, data_ok_o); else passed++;
        end else begin
          total++;
          if (data_ok_o !== 1'b1) $display("FAIL rdi_live: got %b exp 1", data_ok_o); else passed++;
          total++;
          if (pc_o !== 32'h80001000) $display("FAIL rdi_pc: got %h exp 80001000", pc_o); else passed++;
        end
      end
      tick();
    end
    total++; if (k != 3) $display("FAIL rdi_timeout: got %0d responses exp 3", k); else passed++;
  endtask

  task automatic test_redirect_midwait();
    int na = 0;
    int nd = 0;
    do_reset();
    rsp_en = 1'b1; auto_acc = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (inst_req !== 1'b1 || inst_addr !== RST_PC)
        $display("FAIL mw_hold%0d: got req %b addr %h exp 1 %h", i, inst_req, inst_addr, RST_PC);
      else passed++;
      tick();
      redirect_i = (i == 0);
      redirect_pc_i = 32'h80002000;
    end
    inst_addr_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (inst_req && inst_addr_ok) begin
        if (na < 2) begin
          total++;
          if (inst_addr !== (na == 0 ? RST_PC : 32'h80002000))
            $display("FAIL mw_acc%0d: got %h", na, inst_addr);
          else passed++;
        end
        na++;
      end
      if (inst_data_ok) begin
        if (nd < 2) begin
          total++;
          if (data_ok_o !== (nd == 1))
            $display("FAIL mw_dok%0d: got %b exp %b", nd, data_ok_o, nd == 1);
          else passed++;
        end
        if (nd == 1) begin
          total++;
          if (pc_o !== 32'h80002000) $display("FAIL mw_pc: got %h exp 80002000", pc_o); else passed++;
        end
        nd++;
      end
      tick();
    end
    total++; if (na < 2 || nd < 2) $display("FAIL mw_timeout: got %0d/%0d exp 2/2", na, nd); else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h80000002;
    inst_addr_ok = 1'b1; rsp_en = 1'b1; auto_acc = 1'b1;
    tick();
    redirect_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (inst_req !== 1'b0) $display("FAIL mis_req%0d: got %b exp 0", i, inst_req); else passed++;
      total++; if (valid_o !== 1'b1) $display("FAIL mis_valid%0d: got %b exp 1", i, valid_o); else passed++;
      total++; if (exc_o !== 1'b1) $display("FAIL mis_exc%0d: got %b exp 1", i, exc_o); else passed++;
      total++; if (exccode_o !== 5'h04) $display("FAIL mis_code%0d: got %h exp 04", i, exccode_o); else passed++;
      total++; if (pc_o !== 32'h80000002) $display("FAIL mis_pc%0d: got %h exp 80000002", i, pc_o); else passed++;
      tick();
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h80000000;
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    total++; if (inst_req !== 1'b1) $display("FAIL mis_resume: got %b exp 1", inst_req); else passed++;
    total++; if (inst_addr !== 32'h80000000) $display("FAIL mis_addr: got %h exp 80000000", inst_addr); else passed++;
    total++; if (exc_o !== 1'b0) $display("FAIL mis_exc_clr: got %b exp 0", exc_o); else passed++;
    total++; if (exccode_o !== 5'h00) $display("FAIL mis_code_clr: got %h exp 00", exccode_o); else passed++;
    repeat (3) tick();
  endtask

  task automatic test_reset_midflight();
    logic found = 1'b0;
    do_reset();
    inst_addr_ok = 1'b1; auto_acc = 1'b1;
    repeat (4) tick();
    resetn = 1'b0;
    @(negedge clk);
    total++; if (inst_req !== 1'b0) $display("FAIL rmf_req: got %b exp 0", inst_req); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL rmf_valid: got %b exp 0", valid_o); else passed++;
    total++; if (data_ok_o !== 1'b0) $display("FAIL rmf_dok: got %b exp 0", data_ok_o); else passed++;
    total++; if (exc_o !== 1'b0 || exccode_o !== 5'h00) $display("FAIL rmf_exc: got %b %h exp 0 00", exc_o, exccode_o); else passed++;
    total++; if (inst_addr !== RST_PC) $display("FAIL rmf_addr: got %h exp %h", inst_addr, RST_PC); else passed++;
    tick(); tick();
    resetn = 1'b1; rsp_en = 1'b1;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (inst_req && inst_addr_ok) begin
        found = 1'b1;
        total++;
        if (inst_addr !== RST_PC) $display("FAIL rmf_restart: got %h exp %h", inst_addr, RST_PC); else passed++;
      end
      tick();
    end
    total++; if (!found) $display("FAIL rmf_timeout: no request after reset"); else passed++;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_max_out();
    test_redirect_inflight();
    test_redirect_midwait();
    test_misaligned();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
